ahb_lite_burst_tester: RTL and testbench
========================================

AHB_LITE_BURST_TESTER -- requirements
Module: ahb_lite_burst_tester

Interface
REQ-001 SHALL have parameter BURST_CNT, default 1024: WRAP4 bursts per pass (>=1).
REQ-002 SHALL have port HCLK  input  1  bus clock; all state on rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports HADDR output 32, HBURST output 3, HSEL output 1, HSIZE output 3, HTRANS output 2, HWDATA output 32, HWRITE output 1: AHB-Lite master request.
REQ-005 SHALL have ports HRDATA input 32, HREADY input 1, HRESP input 1: AHB-Lite slave response.
REQ-006 SHALL have port STARTADDR  input  32  base byte address of the test window; bits [3:0] are ignored.
REQ-007 SHALL have ports ERRCOUNT output 32 (mismatch/error count) and PASSCOUNT output 8 (completed passes).
REQ-008 SHALL have ports S_WRITE, S_CHECK, S_FAILED, each output 1: write phase, read-check phase, ERRCOUNT nonzero.

Function
REQ-009 States: WAIT, WRITE, READ; WAIT->WRITE on first cycle with HREADY=1 after reset; WRITE->READ after the last data phase of burst BURST_CNT-1; READ->WRITE after the last read data phase, PASSCOUNT+1 (wraps 255->0).
REQ-010 Burst b (0..BURST_CNT-1) base = {STARTADDR[31:4],4'b0} + 16*b; start offset = 4*b[1:0]; beat k address = {base[31:4], (start offset + 4k) mod 16}.
REQ-011 Every beat: HSEL=1, HSIZE=3'b010, HBURST=3'b010 (WRAP4); beat 0 HTRANS=NONSEQ (2'b10), beats 1-3 SEQ (2'b11); HWRITE=1 in WRITE, 0 in READ.
REQ-012 Address phase of beat n overlaps data phase of beat n-1; HWDATA for a beat SHALL be driven in its data phase, one cycle after its address phase.
REQ-013 HREADY=0: HADDR, HTRANS, HBURST, HWRITE, HWDATA SHALL hold; no counter advances.
REQ-014 Between bursts there SHALL be no IDLE cycle; between WRITE and READ, exactly one IDLE cycle (HTRANS=2'b00, HSEL=0).
REQ-015 Expected data for a beat = its byte address (pattern function, see REQ-025).
REQ-016 READ: in each data phase with HREADY=1, HRDATA != expected SHALL increment ERRCOUNT by 1 at the next edge.
REQ-017 HRESP=1 sampled with HREADY=1 in any data phase SHALL increment ERRCOUNT by 1 (once per beat, not added to a mismatch) and the sequence continues.
REQ-018 ERRCOUNT SHALL saturate at 32'hFFFF_FFFF.
REQ-019 S_WRITE=1 only in WRITE, S_CHECK=1 only in READ, S_FAILED = (ERRCOUNT != 0); all registered.
REQ-020 STARTADDR SHALL be sampled only at entry to WRITE; changes mid-pass take effect next pass.
REQ-021 BURST_CNT=1 SHALL yield a 4-beat write, one IDLE, 4-beat read, repeat.

Reset
REQ-022 HRESETn low SHALL immediately force: state WAIT, HTRANS=2'b00, HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HBURST=0, HSIZE=0, ERRCOUNT=0, PASSCOUNT=0, S_WRITE=S_CHECK=S_FAILED=0.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; after release the tester restarts at burst 0 of a WRITE pass.
REQ-024 Release of HRESETn SHALL be synchronised to HCLK by the surrounding system; the block adds no synchroniser.

Configuration
REQ-025 Macro AHB_LITE_BURST_TESTER_PASSINV_EN defined: expected/written data = address XOR {32{PASSCOUNT[0]}} (inverted on odd passes); undefined: data = address on every pass.

Verification
REQ-026 STARTADDR=32'h0000_1004, BURST_CNT=2, HREADY=1 -> write addresses 1000,1004,1008,100C,1014,1018,101C,1010 with HTRANS 2,3,3,3,2,3,3,3 and HWDATA equal to address one cycle later.
REQ-027 Ideal memory model, BURST_CNT=4, run 3 passes -> ERRCOUNT=0, PASSCOUNT=3, S_FAILED=0, exactly one IDLE between WRITE and READ each pass.
REQ-028 Model corrupts read of 32'h0000_1008 once -> ERRCOUNT=1, S_FAILED=1 one cycle later.
REQ-029 HREADY low 3 cycles during beat 2 data phase -> outputs stable for 3 cycles, no duplicated or skipped beat; HRESP=1 on one read beat -> ERRCOUNT +1 only.
REQ-030 HRESETn low mid-READ pass 1 -> all outputs at reset values same cycle; after release WRITE restarts at burst 0, PASSCOUNT=0.
REQ-031 With AHB_LITE_BURST_TESTER_PASSINV_EN, pass 1 writes ~address (32'h1000 -> 32'hFFFF_EFFF) and ERRCOUNT stays 0 on ideal model.

Source files
------------

// File: rtl/ahb_lite_burst_tester.sv
// AHB-Lite WRAP4 burst memory tester: writes an address pattern over a window,
// reads it back, counts mismatches and error responses, then repeats.
// Optional: AHB_LITE_BURST_TESTER_PASSINV_EN inverts the data pattern on odd passes.
module ahb_lite_burst_tester #(
   parameter int unsigned BURST_CNT = 1024
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HSEL,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   input  logic [31:0] STARTADDR,
   output logic [31:0] ERRCOUNT,
   output logic [7:0]  PASSCOUNT,
   output logic        S_WRITE,
   output logic        S_CHECK,
   output logic        S_FAILED
);
   localparam int unsigned BW = (BURST_CNT > 1) ? $clog2(BURST_CNT) : 1;
   localparam logic [BW-1:0] LAST_BURST = BW'(BURST_CNT - 1);
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BURST_WRAP4 = 3'b010;
   localparam logic [2:0] SIZE_WORD   = 3'b010;

   typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_WRITE = 2'd1, ST_READ = 2'd2} state_e;

   state_e        state_q;
   logic          gap_q;       // address phase is the IDLE gap after the last beat of a pass
   logic [27:0]   base_q;      // window base [31:4], captured at start of each WRITE pass
   logic [BW-1:0] burst_q;
   logic [1:0]    beat_q;
   logic          dp_valid_q;
   logic          dp_write_q;
   logic [31:0]   exp_q;
   logic [31:0]   haddr_q;
   logic [31:0]   hwdata_q;
   logic [1:0]    htrans_q;
   logic [2:0]    hburst_q;
   logic [2:0]    hsize_q;
   logic          hsel_q;
   logic          hwrite_q;
   logic [31:0]   errcount_q;
   logic [7:0]    passcount_q;
   logic          s_write_q;
   logic          s_check_q;
   logic          s_failed_q;

   logic          inv_c;
   logic [31:0]   pat_c;
   logic          err_hit_c;
   logic [31:0]   err_nxt_c;
   logic [BW-1:0] burst_inc_c;
   logic          unused_c;

   // Byte address of beat k of burst b: 16-byte block base+b, wrapping start offset 4*b[1:0]
   function automatic logic [31:0] beat_addr(input logic [27:0] base, input logic [BW-1:0] b,
                                             input logic [1:0] k);
      logic [1:0] word;
      word = 2'(b) + k;
      return {base + 28'(b), word, 2'b00};
   endfunction

`ifdef AHB_LITE_BURST_TESTER_PASSINV_EN
   assign inv_c = passcount_q[0];
`else
   assign inv_c = 1'b0;
`endif

   // Data pattern for the beat currently in its address phase
   assign pat_c       = haddr_q ^ {32{inv_c}};
   assign burst_inc_c = burst_q + BW'(1);
   assign unused_c    = ^STARTADDR[3:0];

   // One error per completed data phase: error response, or read mismatch
   assign err_hit_c = HREADY && dp_valid_q && (HRESP || (!dp_write_q && (HRDATA != exp_q)));
   assign err_nxt_c = (err_hit_c && (errcount_q != '1)) ? errcount_q + 32'd1 : errcount_q;

   // Pass sequencer, address/data pipeline and error counting
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_WAIT;
         gap_q       <= 1'b0;
         base_q      <= '0;
         burst_q     <= '0;
         beat_q      <= '0;
         dp_valid_q  <= 1'b0;
         dp_write_q  <= 1'b0;
         exp_q       <= '0;
         haddr_q     <= '0;
         hwdata_q    <= '0;
         htrans_q    <= TR_IDLE;
         hburst_q    <= '0;
         hsize_q     <= '0;
         hsel_q      <= 1'b0;
         hwrite_q    <= 1'b0;
         errcount_q  <= '0;
         passcount_q <= '0;
         s_write_q   <= 1'b0;
         s_check_q   <= 1'b0;
         s_failed_q  <= 1'b0;
      end else begin
         errcount_q <= err_nxt_c;
         s_failed_q <= (err_nxt_c != 32'd0);
         if (HREADY) begin
            case (state_q)
               ST_WAIT: begin
                  state_q   <= ST_WRITE;
                  s_write_q <= 1'b1;
                  base_q    <= STARTADDR[31:4];
                  burst_q   <= '0;
                  beat_q    <= '0;
                  haddr_q   <= {STARTADDR[31:4], 4'h0};
                  htrans_q  <= TR_NONSEQ;
                  hsel_q    <= 1'b1;
                  hwrite_q  <= 1'b1;
                  hburst_q  <= BURST_WRAP4;
                  hsize_q   <= SIZE_WORD;
               end
               default: begin
                  if (gap_q) begin
                     // last data phase of the pass done: start the other phase at burst 0
                     gap_q      <= 1'b0;
                     dp_valid_q <= 1'b0;
                     burst_q    <= '0;
                     beat_q     <= '0;
                     htrans_q   <= TR_NONSEQ;
                     hsel_q     <= 1'b1;
                     if (state_q == ST_WRITE) begin
                        state_q   <= ST_READ;
                        s_write_q <= 1'b0;
                        s_check_q <= 1'b1;
                        hwrite_q  <= 1'b0;
                        haddr_q   <= {base_q, 4'h0};
                     end else begin
                        state_q     <= ST_WRITE;
                        s_write_q   <= 1'b1;
                        s_check_q   <= 1'b0;
                        hwrite_q    <= 1'b1;
                        base_q      <= STARTADDR[31:4];
                        haddr_q     <= {STARTADDR[31:4], 4'h0};
                        passcount_q <= passcount_q + 8'd1;
                     end
                  end else begin
                     // current address phase accepted; it becomes the data phase
                     dp_valid_q <= 1'b1;
                     dp_write_q <= hwrite_q;
                     if (hwrite_q) begin
                        hwdata_q <= pat_c;
                     end else begin
                        exp_q <= pat_c;
                     end
                     if ((beat_q == 2'd3) && (burst_q == LAST_BURST)) begin
                        gap_q    <= 1'b1;
                        htrans_q <= TR_IDLE;
                        hsel_q   <= 1'b0;
                     end else if (beat_q == 2'd3) begin
                        burst_q  <= burst_inc_c;
                        beat_q   <= 2'd0;
                        haddr_q  <= beat_addr(base_q, burst_inc_c, 2'd0);
                        htrans_q <= TR_NONSEQ;
                     end else begin
                        beat_q   <= beat_q + 2'd1;
                        haddr_q  <= beat_addr(base_q, burst_q, beat_q + 2'd1);
                        htrans_q <= TR_SEQ;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign HADDR     = haddr_q;
   assign HBURST    = hburst_q;
   assign HSEL      = hsel_q;
   assign HSIZE     = hsize_q;
   assign HTRANS    = htrans_q;
   assign HWDATA    = hwdata_q;
   assign HWRITE    = hwrite_q;
   assign ERRCOUNT  = errcount_q;
   assign PASSCOUNT = passcount_q;
   assign S_WRITE   = s_write_q;
   assign S_CHECK   = s_check_q;
   assign S_FAILED  = s_failed_q;

endmodule

// File: tb/tb_ahb_lite_burst_tester.sv
// Bench for ahb_lite_burst_tester: ideal AHB-Lite memory slave plus directed checks.
module tb_ahb_lite_burst_tester;
   logic        HCLK;
   logic        HRESETn;
   logic [31:0] HADDR;
   logic [2:0]  HBURST;
   logic        HSEL;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] STARTADDR;
   logic [31:0] ERRCOUNT;
   logic [7:0]  PASSCOUNT;
   logic        S_WRITE;
   logic        S_CHECK;
   logic        S_FAILED;

   ahb_lite_burst_tester #(.BURST_CNT(2)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HADDR(HADDR), .HBURST(HBURST), .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS),
      .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .STARTADDR(STARTADDR), .ERRCOUNT(ERRCOUNT), .PASSCOUNT(PASSCOUNT),
      .S_WRITE(S_WRITE), .S_CHECK(S_CHECK), .S_FAILED(S_FAILED)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        rdy;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        wr;
      logic        wd_chk;
      logic [31:0] wd;
      logic        sw;
      logic        sc;
      logic [7:0]  pc;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // slave model state
   logic [31:0] mem [logic [31:0]];
   logic        dp_v = 1'b0;
   logic        dp_w = 1'b0;
   logic [31:0] dp_a = '0;
   int          idle_run = 0;
   logic        have_prev = 1'b0;
   logic        prev_w = 1'b0;
   int          bpass = 0;
   logic [31:0] corrupt_addr = '0;
   int          corrupt_left = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
`ifdef AHB_LITE_BURST_TESTER_PASSINV_EN
      return a ^ {32{bpass[0]}};
`else
      return a;
`endif
   endfunction

   function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                               input logic wd_chk, input logic [31:0] wd, input logic sw,
                               input logic sc, input logic [7:0] pc);
      vec_t v;
      v.rdy = 1'b1; v.addr = addr; v.trans = trans; v.wr = wr; v.wd_chk = wd_chk;
      v.wd = wd; v.sw = sw; v.sc = sc; v.pc = pc;
      return v;
   endfunction

   // Drive one cycle of slave response (called at a negedge), then advance to the next negedge
   task automatic step(input logic rdy, input logic resp);
      logic        corrupt;
      logic [31:0] rd;
      corrupt = dp_v && !dp_w && (dp_a == corrupt_addr) && (corrupt_left > 0);
      rd      = mem.exists(dp_a) ? mem[dp_a] : 32'hDEAD_BEEF;
      HREADY  = rdy;
      HRESP   = resp;
      HRDATA  = (dp_v && !dp_w) ? (corrupt ? ~rd : rd) : 32'h0;
      if (rdy) begin
         if (dp_v && dp_w) begin
            chk("wdata", HWDATA, pat(dp_a));
            mem[dp_a] = HWDATA;
         end
         if (corrupt) corrupt_left--;
         if (HTRANS == 2'b00) begin
            idle_run++;
         end else begin
            if (have_prev && (HWRITE != prev_w)) begin
               chk("idle_gap", 32'(idle_run), 32'd1);
               if (HWRITE) bpass++;
            end else if (have_prev && (HTRANS == 2'b10)) begin
               chk("no_idle", 32'(idle_run), 32'd0);
            end
            idle_run  = 0;
            prev_w    = HWRITE;
            have_prev = 1'b1;
         end
         dp_v = HTRANS[1];
         dp_a = HADDR;
         dp_w = HWRITE;
      end
      @(negedge HCLK);
   endtask

   task automatic wait_for(input logic [31:0] a, input logic [1:0] t, input logic w,
                           input string nm);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (HADDR == a && HTRANS == t && HWRITE == w) found = 1'b1;
         else step(1'b1, 1'b0);
      end
      chk(nm, 32'(found), 32'd1);
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_ctrl"}, 32'({HTRANS, HSEL, HWRITE, HBURST, HSIZE, S_WRITE, S_CHECK, S_FAILED}),
          32'd0);
      chk({nm, "_haddr"}, HADDR, 32'd0);
      chk({nm, "_hwdata"}, HWDATA, 32'd0);
      chk({nm, "_errcount"}, ERRCOUNT, 32'd0);
      chk({nm, "_passcount"}, 32'(PASSCOUNT), 32'd0);
   endtask

   vec_t vecs [20];

   initial begin
      // Expected outputs per cycle after reset release, STARTADDR=0x1004, BURST_CNT=2, HREADY=1
      vecs[0]  = mk(32'h0,    2'b00, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 8'd0);
      vecs[1]  = mk(32'h1000, 2'b10, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 8'd0);
      vecs[2]  = mk(32'h1004, 2'b11, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0, 8'd0);
      vecs[3]  = mk(32'h1008, 2'b11, 1'b1, 1'b1, 32'h1004, 1'b1, 1'b0, 8'd0);
      vecs[4]  = mk(32'h100C, 2'b11, 1'b1, 1'b1, 32'h1008, 1'b1, 1'b0, 8'd0);
      vecs[5]  = mk(32'h1014, 2'b10, 1'b1, 1'b1, 32'h100C, 1'b1, 1'b0, 8'd0);
      vecs[6]  = mk(32'h1018, 2'b11, 1'b1, 1'b1, 32'h1014, 1'b1, 1'b0, 8'd0);
      vecs[7]  = mk(32'h101C, 2'b11, 1'b1, 1'b1, 32'h1018, 1'b1, 1'b0, 8'd0);
      vecs[8]  = mk(32'h1010, 2'b11, 1'b1, 1'b1, 32'h101C, 1'b1, 1'b0, 8'd0);
      vecs[9]  = mk(32'h0,    2'b00, 1'b0, 1'b1, 32'h1010, 1'b1, 1'b0, 8'd0);
      vecs[10] = mk(32'h1000, 2'b10, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[11] = mk(32'h1004, 2'b11, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[12] = mk(32'h1008, 2'b11, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[13] = mk(32'h100C, 2'b11, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[14] = mk(32'h1014, 2'b10, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[15] = mk(32'h1018, 2'b11, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[16] = mk(32'h101C, 2'b11, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[17] = mk(32'h1010, 2'b11, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[18] = mk(32'h0,    2'b00, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 8'd0);
      vecs[19] = mk(32'h1000, 2'b10, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 8'd1);

      HRESETn   = 1'b0;
      HREADY    = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = '0;
      STARTADDR = 32'h0000_1004;
      @(negedge HCLK);
      @(negedge HCLK);
      chk_reset("reset");
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Table: first write pass, IDLE gap, read pass, start of pass 1
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'(vecs[i].trans));
         chk($sformatf("v%0d_hsel", i), 32'(HSEL), 32'(vecs[i].trans != 2'b00));
         if (vecs[i].trans != 2'b00) begin
            chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].addr);
            chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(vecs[i].wr));
            chk($sformatf("v%0d_hsize_hburst", i), 32'({HSIZE, HBURST}), 32'h12);
         end
         if (vecs[i].wd_chk) chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].wd);
         chk($sformatf("v%0d_s_write", i), 32'(S_WRITE), 32'(vecs[i].sw));
         chk($sformatf("v%0d_s_check", i), 32'(S_CHECK), 32'(vecs[i].sc));
         chk($sformatf("v%0d_passcount", i), 32'(PASSCOUNT), 32'(vecs[i].pc));
         step(vecs[i].rdy, 1'b0);
      end

      // Ideal memory until the start of pass 3
      for (int i = 0; i < 200 && bpass < 3; i++) step(1'b1, 1'b0);
      chk("three_pass_bpass", 32'(bpass), 32'd3);
      chk("three_pass_passcount", 32'(PASSCOUNT), 32'd3);
      chk("three_pass_errcount", ERRCOUNT, 32'd0);
      chk("three_pass_s_failed", 32'(S_FAILED), 32'd0);

      // One corrupted read of 0x1008
      corrupt_addr = 32'h0000_1008;
      corrupt_left = 1;
      for (int i = 0; i < 100 && corrupt_left > 0; i++) step(1'b1, 1'b0);
      chk("corrupt_applied", 32'(corrupt_left), 32'd0);
      chk("corrupt_errcount", ERRCOUNT, 32'd1);
      chk("corrupt_s_failed", 32'(S_FAILED), 32'd1);

      // HREADY low for 3 cycles during the data phase of write beat 2
      wait_for(32'h1008, 2'b11, 1'b1, "find_wr_beat2");
      step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall%0d_haddr", i), HADDR, 32'h100C);
         chk($sformatf("stall%0d_htrans", i), 32'(HTRANS), 32'h3);
         chk($sformatf("stall%0d_hwrite", i), 32'(HWRITE), 32'h1);
         chk($sformatf("stall%0d_hwdata", i), HWDATA, pat(32'h1008));
         step(i == 3, 1'b0);
      end
      chk("post_stall_haddr", HADDR, 32'h1014);
      chk("post_stall_htrans", 32'(HTRANS), 32'h2);
      chk("post_stall_hwdata", HWDATA, pat(32'h100C));

      // Error response together with bad data on one read beat counts once
      wait_for(32'h1004, 2'b11, 1'b0, "find_rd_beat1");
      corrupt_addr = 32'h0000_1004;
      corrupt_left = 1;
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("hresp_errcount", ERRCOUNT, 32'd2);
      step(1'b1, 1'b0);
      chk("hresp_no_more", ERRCOUNT, 32'd2);

      // Reset in the middle of a read pass
      wait_for(32'h1014, 2'b10, 1'b0, "find_rd_burst1");
      HRESETn = 1'b0;
      #1;
      chk_reset("midread_reset");
      dp_v = 1'b0; have_prev = 1'b0; idle_run = 0; bpass = 0; corrupt_left = 0;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      chk("restart_wait_htrans", 32'(HTRANS), 32'd0);
      step(1'b1, 1'b0);
      chk("restart_haddr", HADDR, 32'h1000);
      chk("restart_htrans", 32'(HTRANS), 32'h2);
      chk("restart_hwrite", 32'(HWRITE), 32'h1);
      chk("restart_passcount", 32'(PASSCOUNT), 32'd0);
      chk("restart_errcount", ERRCOUNT, 32'd0);

      // STARTADDR change mid-pass takes effect at the next WRITE pass
      step(1'b1, 1'b0);
      STARTADDR = 32'h0000_2000;
      wait_for(32'h1000, 2'b10, 1'b0, "old_window_read");
      wait_for(32'h2000, 2'b10, 1'b1, "new_window_write");
      chk("new_window_passcount", 32'(PASSCOUNT), 32'd1);
      step(1'b1, 1'b0);
      wait_for(32'h2000, 2'b10, 1'b0, "new_window_read");
      step(1'b1, 1'b0);
      wait_for(32'h2000, 2'b10, 1'b1, "new_window_next_pass");
      chk("new_window_errcount", ERRCOUNT, 32'd0);
      chk("new_window_passcount2", 32'(PASSCOUNT), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
